// File: rtl/mole_pkg.sv
// Shared constants, FSM state type and small helpers for the mole-hit encoder.
package mole_pkg;

    localparam int unsigned NUM_MOLES = 5;

    localparam logic [2:0] HIT_NONE = 3'b000;
    localparam logic [2:0] HIT_M0   = 3'b001;
    localparam logic [2:0] HIT_M1   = 3'b010;
    localparam logic [2:0] HIT_M2   = 3'b011;
    localparam logic [2:0] HIT_M3   = 3'b100;
    localparam logic [2:0] HIT_M4   = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Code of the lowest-index set bit; HIT_NONE when the vector is empty.
    function automatic logic [2:0] lowest_code(input logic [NUM_MOLES-1:0] vec);
        lowest_code = HIT_NONE;
        for (int i = NUM_MOLES - 1; i >= 0; i--) begin
            if (vec[i]) lowest_code = 3'(i + 1);
        end
    endfunction

    function automatic logic [2:0] count_ones(input logic [NUM_MOLES-1:0] vec);
        count_ones = '0;
        for (int i = 0; i < NUM_MOLES; i++) begin
            count_ones = count_ones + {2'b00, vec[i]};
        end
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser followed by a stability-counter debouncer for one button.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic level,
    output logic level_next
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        level_d = level_q;
        count_d = '0;
        if (sync2_q != level_q) begin
            if (count_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            count_q <= '0;
        end else begin
            sync1_q <= button;
            sync2_q <= sync1_q;
            level_q <= level_d;
            count_q <= count_d;
        end
    end

    assign level      = level_q;
    assign level_next = level_d;

endmodule

// File: rtl/mole_hit_encoder.sv
// Debounces five mole buttons and encodes each accepted press into a held 3-bit hit code.
// Optional HIT_STATS_EN adds saturating press/drop counters.
module mole_hit_encoder
    import mole_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned HOLD_CYCLES     = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NUM_MOLES-1:0] buttons,
    output logic [2:0]           hit,
    output logic                 hit_valid,
    output logic                 multi_press,
    output logic [NUM_MOLES-1:0] held
`ifdef HIT_STATS_EN
    ,
    output logic [7:0]           press_count,
    output logic [7:0]           drop_count
`endif
);

    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [NUM_MOLES-1:0] held_next;
    logic [NUM_MOLES-1:0] rise;
    logic                 accept;

    state_t               state_q, state_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic [2:0]           hit_q, hit_d;
    logic                 hit_valid_q, hit_valid_d;
    logic                 multi_q, multi_d;

    for (genvar i = 0; i < NUM_MOLES; i++) begin : g_deb
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clock     (clock),
            .reset     (reset),
            .button    (buttons[i]),
            .level     (held[i]),
            .level_next(held_next[i])
        );
    end

    // Edges are taken on the debounced level so the code lands with the held bit.
    assign rise   = held_next & ~held;
    assign accept = (state_q == ST_IDLE) && enable && (rise != '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hit_q       <= HIT_NONE;
            hit_valid_q <= 1'b0;
            multi_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hit_q       <= hit_d;
            hit_valid_q <= hit_valid_d;
            multi_q     <= multi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (accept) state_d = ST_HOLD;
            ST_HOLD: begin
                if (!enable)              state_d = ST_IDLE;
                else if (hold_q == '0)    state_d = ST_RELEASE;
            end
            ST_RELEASE: if (!enable || held == '0) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hit_d       = hit_q;
        hold_d      = hold_q;
        hit_valid_d = 1'b0;
        multi_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                hit_d = HIT_NONE;
                if (accept) begin
                    hit_d       = lowest_code(rise);
                    hold_d      = HW'(HOLD_CYCLES - 1);
                    hit_valid_d = 1'b1;
                    multi_d     = (rise & (rise - 1'b1)) != '0;
                end
            end
            ST_HOLD: begin
                if (!enable || hold_q == '0) hit_d = HIT_NONE;
                else                         hold_d = hold_q - 1'b1;
            end
            ST_RELEASE: hit_d = HIT_NONE;
            default:    hit_d = HIT_NONE;
        endcase
    end

    assign hit         = hit_q;
    assign hit_valid   = hit_valid_q;
    assign multi_press = multi_q;

`ifdef HIT_STATS_EN
    logic [2:0] drop_n;
    logic [8:0] drop_sum;
    logic [7:0] press_q, drop_q;

    always_comb begin
        drop_n = '0;
        if (accept)                   drop_n = count_ones(rise) - 3'd1;
        else if (state_q != ST_IDLE)  drop_n = count_ones(rise);
        drop_sum = {1'b0, drop_q} + {6'b0, drop_n};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            press_q <= '0;
            drop_q  <= '0;
        end else begin
            if (hit_valid_d && press_q != 8'hff) press_q <= press_q + 8'd1;
            drop_q <= drop_sum[8] ? 8'hff : drop_sum[7:0];
        end
    end

    assign press_count = press_q;
    assign drop_count  = drop_q;
`endif

endmodule

// File: tb/tb_mole_hit_encoder.sv
// Directed and randomized checks of mole_hit_encoder against a run-length / countdown model.
module tb_mole_hit_encoder;

    localparam int DEB  = 8;
    localparam int HOLD = 4;

    logic       clock   = 1'b0;
    logic       reset   = 1'b0;
    logic       enable  = 1'b0;
    logic [4:0] buttons = '0;
    logic [2:0] hit;
    logic       hit_valid;
    logic       multi_press;
    logic [4:0] held;
`ifdef HIT_STATS_EN
    logic [7:0] press_count;
    logic [7:0] drop_count;
`endif

    always #5 clock = ~clock;

    mole_hit_encoder #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .buttons    (buttons),
        .hit        (hit),
        .hit_valid  (hit_valid),
        .multi_press(multi_press),
        .held       (held)
`ifdef HIT_STATS_EN
        ,
        .press_count(press_count),
        .drop_count (drop_count)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: raw history pipe, run length of disagreement, remaining hit cycles.
    bit [4:0] m_p1, m_p2, m_held;
    int       m_run [5];
    int       m_left;
    bit       m_wait;
    bit [2:0] m_code;
    bit       m_hv, m_mp;
    int       m_press, m_drop;

    // Observations of the DUT used for directed summaries.
    int       nz_cycles, hv_pulses, mp_pulses;
    logic [2:0] last_hit;

    task automatic model_update();
        bit [4:0] nh;
        bit [4:0] rise;
        int       pc;
        int       k;
        if (!reset) begin
            m_p1 = '0; m_p2 = '0; m_held = '0;
            for (int i = 0; i < 5; i++) m_run[i] = 0;
            m_left = 0; m_wait = 0; m_code = '0; m_hv = 0; m_mp = 0;
            m_press = 0; m_drop = 0;
            return;
        end
        nh = m_held;
        for (int i = 0; i < 5; i++) begin
            if (m_p2[i] != m_held[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    nh[i] = ~m_held[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_p2 = m_p1;
        m_p1 = buttons;
        rise = nh & ~m_held;
        pc = $countones(rise);
        m_hv = 0;
        m_mp = 0;
        if (m_left > 0 || m_wait) begin
            m_drop += pc;
            if (!enable) begin
                m_left = 0;
                m_wait = 0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_wait = 1;
            end else if (m_held == 5'b0) begin
                m_wait = 0;
            end
        end else if (enable && pc > 0) begin
            k = -1;
            for (int i = 0; i < 5; i++) if (rise[i] && k < 0) k = i;
            m_code = 3'(k + 1);
            m_left = HOLD;
            m_hv = 1;
            m_mp = (pc > 1);
            m_press++;
            m_drop += pc - 1;
        end
        m_held = nh;
    endtask

    task automatic step();
        model_update();
        @(posedge clock);
        #1;
        check("hit", 8'(hit), 8'((m_left > 0) ? m_code : 3'b000));
        check("hit_valid", 8'(hit_valid), 8'(m_hv));
        check("multi_press", 8'(multi_press), 8'(m_mp));
        check("held", 8'(held), 8'(m_held));
`ifdef HIT_STATS_EN
        check("press_count", press_count, 8'((m_press > 255) ? 255 : m_press));
        check("drop_count", drop_count, 8'((m_drop > 255) ? 255 : m_drop));
`endif
        if (hit != 3'b000) begin
            nz_cycles++;
            last_hit = hit;
        end
        if (hit_valid)   hv_pulses++;
        if (multi_press) mp_pulses++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_obs();
        nz_cycles = 0;
        hv_pulses = 0;
        mp_pulses = 0;
        last_hit  = 3'b000;
    endtask

    initial begin
        clear_obs();
        // 1: reset with all buttons down, then debounce without enable
        reset = 1'b0; enable = 1'b0; buttons = 5'b11111;
        run(3);
        check("rst_hit", 8'(hit), 8'h00);
        check("rst_held", 8'(held), 8'h00);
        reset = 1'b1;
        run(10);
        check("t1_held", 8'(held), 8'h1f);
        check("t1_nofire", 8'(hv_pulses), 8'h00);
        buttons = 5'b00000;
        run(12);

        // 2: clean single press
        enable = 1'b1; clear_obs();
        buttons = 5'b00100;
        run(10);
        check("t2_code", 8'(hit), 8'h03);
        run(10);
        check("t2_len", 8'(nz_cycles), 8'd4);
        check("t2_pulses", 8'(hv_pulses), 8'd1);
        buttons = 5'b00000;
        run(12);

        // 3: simultaneous press of mole1 and mole3
        clear_obs();
        buttons = 5'b01010;
        run(20);
        check("t3_code", 8'(last_hit), 8'h02);
        check("t3_len", 8'(nz_cycles), 8'd4);
        check("t3_multi", 8'(mp_pulses), 8'd1);
        buttons = 5'b00000;
        run(12);

        // 4: short glitch, then a real press
        clear_obs();
        buttons = 5'b00001;
        run(5);
        buttons = 5'b00000;
        run(15);
        check("t4_glitch", 8'(nz_cycles), 8'd0);
        buttons = 5'b00001;
        run(16);
        check("t4_code", 8'(last_hit), 8'h01);
        buttons = 5'b00000;
        run(12);

        // 5: second button while first still held is dropped
        clear_obs();
        buttons = 5'b10000;
        run(16);
        buttons = 5'b10001;
        run(16);
        check("t5_code", 8'(last_hit), 8'h05);
        check("t5_pulses", 8'(hv_pulses), 8'd1);
        buttons = 5'b00000;
        run(12);
        buttons = 5'b00001;
        run(16);
        check("t5_rearm", 8'(last_hit), 8'h01);
        check("t5_pulses2", 8'(hv_pulses), 8'd2);
        buttons = 5'b00000;
        run(12);

        // 6: enable drop and reset mid-hold
        buttons = 5'b00100;
        run(11);
        enable = 1'b0;
        run(1);
        check("t6_en_abort", 8'(hit), 8'h00);
        enable = 1'b1;
        run(4);
        buttons = 5'b00000;
        run(12);
        buttons = 5'b00100;
        run(11);
        reset = 1'b0;
        run(1);
        check("t6_rst_hit", 8'(hit), 8'h00);
        check("t6_rst_held", 8'(held), 8'h00);
        reset = 1'b1;
        buttons = 5'b00000;
        run(5);

        // Randomized segments
        for (int s = 0; s < 150; s++) begin
            buttons = 5'($urandom & $urandom);
            if ($urandom_range(0, 9) == 0) enable = ~enable;
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b0;
                run(int'($urandom_range(1, 2)));
                reset = 1'b1;
            end
            run(int'($urandom_range(1, 25)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
